i8088_bus_frontend: RTL

Decodes 8088 minimum-mode bus cycles (ALE, RD_N, WR_N, IO_M, multiplexed AD) into the level-held request strobes, address, strobe and data consumed by the AXI capture stage. Holds the CPU in wait states via READY until the capture stage reports idle, then returns read data on AD. Sits between the CPU pins and the AXI capture stage, entirely in the BUS_CLK domain; BUS_CLK is the clock driving the 8088 CLK pin.

---
 rtl/bus_pkg.sv | 26 ++
 rtl/i8088_addr_latch.sv | 53 +++++
 rtl/i8088_bus_frontend.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared types and defaults for the 8088 minimum-mode bus front end.
package bus_pkg;

    // Bus-cycle sequencer states
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_WDATA = 3'd2,
        S_ISSUE = 3'd3,
        S_WAIT  = 3'd4,
        S_DONE  = 3'd5
    } bus_state_t;

    // Default AXI windows for memory and I/O space
    localparam logic [31:0] MEM_BASE_DEFAULT = 32'h4000_0000;
    localparam logic [31:0] IO_BASE_DEFAULT  = 32'h4010_0000;

    // 20-bit CPU physical address
    typedef logic [19:0] cpu_addr_t;

    // One-hot byte lane for an 8-bit access at the given low address bits
    function automatic logic [3:0] lane_strobe(input logic [1:0] low);
        lane_strobe = 4'b0001 << low;
    endfunction

endpackage

// File: rtl/i8088_addr_latch.sv
// ALE-qualified capture of the CPU address and IO_M, plus mapping into the
// AXI memory or I/O window. Also flags the ALE falling edge that follows
// a capture, so a stray ALE outside the enabled window never starts a cycle.
module i8088_addr_latch
    import bus_pkg::*;
#(
    parameter int          ADDR_WIDTH = 32,
    parameter logic [31:0] MEM_BASE   = MEM_BASE_DEFAULT,
    parameter logic [31:0] IO_BASE    = IO_BASE_DEFAULT
) (
    input  logic                  BUS_CLK,
    input  logic                  RESETN,
    input  logic                  capture_en,
    input  logic                  ALE,
    input  logic [7:0]            AD_in,
    input  logic [11:0]           A_hi,
    input  logic                  IO_M,
    output logic                  ale_fall,
    output logic [ADDR_WIDTH-1:0] mapped_addr
);

    cpu_addr_t addr_q;
    logic      io_m_q;
    logic      armed_q;

    // Track address every cycle ALE is high while capture is enabled
    always_ff @(posedge BUS_CLK or negedge RESETN) begin
        if (!RESETN) begin
            addr_q  <= '0;
            io_m_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            armed_q <= capture_en && ALE;
            if (capture_en && ALE) begin
                addr_q <= {A_hi, AD_in};
                io_m_q <= IO_M;
            end
        end
    end

    assign ale_fall = capture_en && armed_q && !ALE;

    // Map into the I/O window (16-bit port) or the memory window (20-bit)
    always_comb begin
        mapped_addr = '0;
        if (io_m_q) begin
            mapped_addr = ADDR_WIDTH'(IO_BASE) + ADDR_WIDTH'(addr_q[15:0]);
        end else begin
            mapped_addr = ADDR_WIDTH'(MEM_BASE) + ADDR_WIDTH'(addr_q);
        end
    end

endmodule

// File: rtl/i8088_bus_frontend.sv
// 8088 minimum-mode bus decoder feeding the AXI capture stage.
// Optional feature macro: BUS_TIMEOUT_EN adds a watchdog over ISSUE/WAIT
// that forces completion with AD_out = 8'hFF after TIMEOUT cycles.
// Handshake: a request strobe rises with A/D/wstrb stable and stays high
// at least SETTLE cycles; it drops only after axi_busy is sampled low in
// WAIT. READY is held low from ALE fall until the cycle after the strobes
// drop, and AD_out is valid whenever READY rises on a read.
module i8088_bus_frontend
    import bus_pkg::*;
#(
    parameter int          ADDR_WIDTH = 32,
    parameter logic [31:0] MEM_BASE   = MEM_BASE_DEFAULT,
    parameter logic [31:0] IO_BASE    = IO_BASE_DEFAULT,
    parameter int          SETTLE     = 4,
    parameter int          TIMEOUT    = 1024
) (
    input  logic                  BUS_CLK,
    input  logic                  RESETN,
    input  logic [7:0]            AD_in,
    input  logic [11:0]           A_hi,
    input  logic                  ALE,
    input  logic                  RD_N,
    input  logic                  WR_N,
    input  logic                  IO_M,
    output logic [7:0]            AD_out,
    output logic                  AD_oe,
    output logic                  READY,
    output logic [ADDR_WIDTH-1:0] A,
    output logic [3:0]            wstrb,
    output logic [31:0]           D,
    output logic                  rdaddr_fetch,
    output logic                  wraddr_fetch,
    output logic                  wrdata_fetch,
    input  logic                  axi_busy,
    input  logic [7:0]            read_data,
    output bus_state_t            dbg_state
);

    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE - 1);

    // Reject configurations the handshake cannot honour
    if (SETTLE < 3 || TIMEOUT < 1) begin : g_param_check
        $error("i8088_bus_frontend: SETTLE must be >= 3 and TIMEOUT >= 1");
    end

    bus_state_t            state, state_nxt;
    logic                  is_read_q, is_read_nxt;
    logic [15:0]           settle_cnt, settle_nxt;
    logic [ADDR_WIDTH-1:0] a_nxt;
    logic [3:0]            wstrb_nxt;
    logic [31:0]           d_nxt;
    logic                  rdaddr_nxt, wraddr_nxt, wrdata_nxt;
    logic                  ready_nxt, ad_oe_nxt;
    logic [7:0]            ad_out_nxt;
    logic                  ale_fall;
    logic [ADDR_WIDTH-1:0] mapped_addr;
    logic                  wd_expired;

    i8088_addr_latch #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .MEM_BASE   (MEM_BASE),
        .IO_BASE    (IO_BASE)
    ) u_addr_latch (
        .BUS_CLK     (BUS_CLK),
        .RESETN      (RESETN),
        .capture_en  (state == S_IDLE),
        .ALE         (ALE),
        .AD_in       (AD_in),
        .A_hi        (A_hi),
        .IO_M        (IO_M),
        .ale_fall    (ale_fall),
        .mapped_addr (mapped_addr)
    );

`ifdef BUS_TIMEOUT_EN
    logic [31:0] wd_cnt;

    // Watchdog counts cycles spent waiting on the capture stage
    always_ff @(posedge BUS_CLK or negedge RESETN) begin
        if (!RESETN) begin
            wd_cnt <= '0;
        end else if (state == S_ISSUE || state == S_WAIT) begin
            wd_cnt <= wd_cnt + 32'd1;
        end else begin
            wd_cnt <= '0;
        end
    end

    assign wd_expired = (state == S_ISSUE || state == S_WAIT) &&
                        (wd_cnt == 32'(TIMEOUT - 1));
`else
    assign wd_expired = 1'b0;
`endif

    // State and all registered outputs
    always_ff @(posedge BUS_CLK or negedge RESETN) begin
        if (!RESETN) begin
            state        <= S_IDLE;
            is_read_q    <= 1'b0;
            settle_cnt   <= '0;
            A            <= '0;
            wstrb        <= '0;
            D            <= '0;
            rdaddr_fetch <= 1'b0;
            wraddr_fetch <= 1'b0;
            wrdata_fetch <= 1'b0;
            READY        <= 1'b1;
            AD_out       <= '0;
            AD_oe        <= 1'b0;
        end else begin
            state        <= state_nxt;
            is_read_q    <= is_read_nxt;
            settle_cnt   <= settle_nxt;
            A            <= a_nxt;
            wstrb        <= wstrb_nxt;
            D            <= d_nxt;
            rdaddr_fetch <= rdaddr_nxt;
            wraddr_fetch <= wraddr_nxt;
            wrdata_fetch <= wrdata_nxt;
            READY        <= ready_nxt;
            AD_out       <= ad_out_nxt;
            AD_oe        <= ad_oe_nxt;
        end
    end

    // Next-state and next-output decode; everything holds unless changed
    always_comb begin
        state_nxt   = state;
        is_read_nxt = is_read_q;
        settle_nxt  = settle_cnt;
        a_nxt       = A;
        wstrb_nxt   = wstrb;
        d_nxt       = D;
        rdaddr_nxt  = rdaddr_fetch;
        wraddr_nxt  = wraddr_fetch;
        wrdata_nxt  = wrdata_fetch;
        ready_nxt   = READY;
        ad_out_nxt  = AD_out;
        ad_oe_nxt   = AD_oe;
        case (state)
            S_IDLE: begin
                ready_nxt = 1'b1;
                ad_oe_nxt = 1'b0;
                if (ale_fall) begin
                    state_nxt = S_ADDR;
                    ready_nxt = 1'b0;
                end
            end
            S_ADDR: begin
                // Read wins if both strobes are low
                if (!RD_N) begin
                    state_nxt   = S_ISSUE;
                    is_read_nxt = 1'b1;
                    a_nxt       = mapped_addr;
                    wstrb_nxt   = lane_strobe(mapped_addr[1:0]);
                    rdaddr_nxt  = 1'b1;
                    settle_nxt  = '0;
                end else if (!WR_N) begin
                    state_nxt = S_WDATA;
                end
            end
            S_WDATA: begin
                // Data is valid on AD one cycle after WR_N falls
                state_nxt   = S_ISSUE;
                is_read_nxt = 1'b0;
                a_nxt       = mapped_addr;
                wstrb_nxt   = lane_strobe(mapped_addr[1:0]);
                d_nxt       = {4{AD_in}};
                wraddr_nxt  = 1'b1;
                wrdata_nxt  = 1'b1;
                settle_nxt  = '0;
            end
            S_ISSUE: begin
                if (wd_expired) begin
                    state_nxt  = S_DONE;
                    rdaddr_nxt = 1'b0;
                    wraddr_nxt = 1'b0;
                    wrdata_nxt = 1'b0;
                    ad_out_nxt = 8'hFF;
                end else if (settle_cnt == SETTLE_LAST) begin
                    state_nxt = S_WAIT;
                end else begin
                    settle_nxt = settle_cnt + 16'd1;
                end
            end
            S_WAIT: begin
                if (wd_expired) begin
                    state_nxt  = S_DONE;
                    rdaddr_nxt = 1'b0;
                    wraddr_nxt = 1'b0;
                    wrdata_nxt = 1'b0;
                    ad_out_nxt = 8'hFF;
                end else if (!axi_busy) begin
                    state_nxt  = S_DONE;
                    rdaddr_nxt = 1'b0;
                    wraddr_nxt = 1'b0;
                    wrdata_nxt = 1'b0;
                    if (is_read_q) begin
                        ad_out_nxt = read_data;
                    end
                end
            end
            S_DONE: begin
                ready_nxt = 1'b1;
                ad_oe_nxt = is_read_q && !RD_N;
                if (RD_N && WR_N) begin
                    ad_oe_nxt = 1'b0;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign dbg_state = state;

endmodule
